fifo_read_ctrl: RTL and testbench

- Read-side controller for the team's single-clock FIFO; the counterpart of the write-pointer counter that drives the write side.
- Owns the read pointer and compares it against the incoming write pointer to derive empty and level.
- Issues reads to the FIFO's synchronous-read RAM (1-cycle latency).
- Presents data to the consumer through a 2-entry output buffer with valid/ready handshake, sustaining 1 word/cycle.

---
 rtl/fifo_read_ctrl.sv | 134 +++++++++++++
 tb/tb_fifo_read_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side controller for the single-clock FIFO.
// Owns the read pointer, derives empty/level from the write pointer, issues
// reads to the 1-cycle-latency RAM and presents data through a 2-entry
// valid/ready output buffer that sustains one word per cycle.
//
// Ports:
//   CLK, reset        clock (rising edge), async active-low reset
//   wr_ptr            write pointer from write side (MSB = wrap bit)
//   flush             synchronous discard of all unread data
//   mem_re/mem_raddr  RAM read request; mem_rdata valid the cycle after
//   rd_ptr            read pointer returned to write side
//   dout/dout_valid/dout_ready  consumer handshake
//   empty, level      combinational pointer compare
//   almost_empty      registered, only with FIFO_RD_ALMOST_EMPTY_EN defined
module fifo_read_ctrl #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 8
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    parameter int unsigned AE_THRESH = 2
`endif
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W:0]   wr_ptr,
    input  logic              flush,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   rd_ptr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              empty,
    output logic [ADDR_W:0]   level
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    output logic              almost_empty
`endif
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;

    logic              pop_c;
    logic [2:0]        occ_c;
    logic [1:0]        slot_c;

    // Pointer compare, pop and issue decision
    always_comb begin
        pop_c  = (count_q != 2'd0) & dout_ready;
        // buffer entries plus the read in flight, minus what leaves this cycle
        occ_c  = 3'(count_q) + 3'(inflight_q) - 3'(pop_c);
        slot_c = count_q - 2'(pop_c);
        empty  = (wr_ptr == rd_ptr_q);
        level  = wr_ptr - rd_ptr_q;
        mem_re = reset & ~empty & ~flush & (occ_c < 3'd2);
    end

    // Next-state: pointer advance, buffer shift and capture, flush override
    always_comb begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(mem_re);
        inflight_d = mem_re;
        count_d    = count_q - 2'(pop_c) + 2'(inflight_q);
        buf0_d     = pop_c ? buf1_q : buf0_q;
        buf1_d     = buf1_q;
        // returning word lands behind whatever remains after the pop
        if (inflight_q) begin
            if (slot_c == 2'd0) begin
                buf0_d = mem_rdata;
            end else begin
                buf1_d = mem_rdata;
            end
        end
        if (flush) begin
            rd_ptr_d   = wr_ptr;
            inflight_d = 1'b0;
            count_d    = 2'd0;
            buf0_d     = buf0_q;
            buf1_d     = buf1_q;
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    assign rd_ptr     = rd_ptr_q;
    assign mem_raddr  = rd_ptr_q[ADDR_W-1:0];
    assign dout       = buf0_q;
    assign dout_valid = (count_q != 2'd0);

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    localparam int unsigned SUM_W = PTR_W + 2;

    logic             almost_empty_q, almost_empty_d;
    logic [SUM_W-1:0] ae_sum_c;

    // Total occupancy after this edge: RAM words unissued + in flight + buffered
    always_comb begin
        ae_sum_c       = SUM_W'(wr_ptr - rd_ptr_d) + SUM_W'(count_d) + SUM_W'(inflight_d);
        almost_empty_d = (ae_sum_c <= SUM_W'(AE_THRESH));
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            almost_empty_q <= 1'b1;
        end else begin
            almost_empty_q <= almost_empty_d;
        end
    end

    assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a behavioural sync-read RAM.
module tb_fifo_read_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic              CLK;
    logic              reset;
    logic [PTR_W-1:0]  wr_ptr;
    logic              flush;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              empty;
    logic [PTR_W-1:0]  level;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    logic              almost_empty;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] ram [16];
    logic [ADDR_W-1:0] raddr_log [$];

    fifo_read_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .wr_ptr       (wr_ptr),
        .flush        (flush),
        .mem_re       (mem_re),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata),
        .rd_ptr       (rd_ptr),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .empty        (empty),
        .level        (level)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        ,
        .almost_empty (almost_empty)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous-read RAM, one cycle latency
    initial mem_rdata = '0;
    always @(posedge CLK) begin
        if (mem_re) mem_rdata <= ram[mem_raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Write side: store n words starting at value base, advance wr_ptr
    task automatic push(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            ram[wr_ptr[ADDR_W-1:0]] = base + 8'(i);
            wr_ptr = wr_ptr + 5'd1;
        end
    endtask

    // Consume n words with dout_ready high, checking order; bounded
    task automatic drain(input int n, input logic [7:0] base, input string tag,
                         output int first, output int last);
        int got;
        got   = 0;
        first = -1;
        last  = -1;
        dout_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got < n; cyc++) begin
            @(negedge CLK);
            if (mem_re) raddr_log.push_back(mem_raddr);
            if (dout_valid) begin
                check($sformatf("%s_word%0d", tag, got), 32'(dout), 32'(8'(base + 8'(got))));
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            tick();
        end
        check({tag, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        int first, last, issued;

        reset      = 1'b0;
        wr_ptr     = '0;
        flush      = 1'b0;
        dout_ready = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = '0;

        // Reset state
        tick();
        tick();
        @(negedge CLK);
        check("rst_rd_ptr",     32'(rd_ptr),     32'h0);
        check("rst_empty",      32'(empty),      32'h1);
        check("rst_level",      32'(level),      32'h0);
        check("rst_dout_valid", 32'(dout_valid), 32'h0);
        check("rst_mem_re",     32'(mem_re),     32'h0);
        check("rst_dout",       32'(dout),       32'h0);
        tick();
        reset = 1'b1;

        // First word: issued the cycle empty drops
        ram[0] = 8'hA5;
        wr_ptr = 5'd1;
        @(negedge CLK);
        check("first_mem_re", 32'(mem_re),     32'h1);
        check("first_raddr",  32'(mem_raddr),  32'h0);
        check("first_empty",  32'(empty),      32'h0);
        check("first_level",  32'(level),      32'h1);
        check("first_valid0", 32'(dout_valid), 32'h0);
        tick();
        @(negedge CLK);
        check("first_empty2", 32'(empty),      32'h1);
        check("first_re2",    32'(mem_re),     32'h0);
        check("first_rd_ptr", 32'(rd_ptr),     32'h1);
        tick();
        @(negedge CLK);
        check("first_valid", 32'(dout_valid), 32'h1);
        check("first_dout",  32'(dout),       32'hA5);
        dout_ready = 1'b1;
        tick();
        @(negedge CLK);
        check("first_popped", 32'(dout_valid), 32'h0);
        dout_ready = 1'b0;
        tick();

        // Restart from pointer 0
        reset  = 1'b0;
        wr_ptr = '0;
        tick();
        reset  = 1'b1;

        // Full-depth burst, one pop per cycle
        push(16, 8'h00);
        @(negedge CLK);
        check("burst_level", 32'(level), 32'h10);
        tick();
        drain(16, 8'h00, "burst", first, last);
        check("burst_rate", 32'(last - first), 32'd15);
        @(negedge CLK);
        check("burst_empty",  32'(empty),      32'h1);
        check("burst_rd_ptr", 32'(rd_ptr),     32'h10);
        check("burst_valid",  32'(dout_valid), 32'h0);
        tick();

        // Backpressure: only two reads may be outstanding
        dout_ready = 1'b0;
        push(10, 8'h40);
        issued = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (mem_re) issued++;
            tick();
        end
        check("bp_issued", 32'(issued), 32'd2);
        @(negedge CLK);
        check("bp_level", 32'(level),      32'd8);
        check("bp_valid", 32'(dout_valid), 32'h1);
        check("bp_dout",  32'(dout),       32'h40);
        tick();
        drain(10, 8'h40, "bp", first, last);

        // Move read pointer to 5'h1E, then read across the wrap
        push(4, 8'h60);
        drain(4, 8'h60, "pre", first, last);
        @(negedge CLK);
        check("wrap_start", 32'(rd_ptr), 32'h1E);
        tick();
        push(4, 8'h80);
        check("wrap_wr_ptr", 32'(wr_ptr), 32'h02);
        raddr_log.delete();
        @(negedge CLK);
        check("wrap_level", 32'(level), 32'd4);
        if (mem_re) raddr_log.push_back(mem_raddr);
        tick();
        drain(4, 8'h80, "wrap", first, last);
        check("wrap_nreads", 32'(raddr_log.size()), 32'd4);
        if (raddr_log.size() == 4) begin
            check("wrap_addr0", 32'(raddr_log[0]), 32'd14);
            check("wrap_addr1", 32'(raddr_log[1]), 32'd15);
            check("wrap_addr2", 32'(raddr_log[2]), 32'd0);
            check("wrap_addr3", 32'(raddr_log[3]), 32'd1);
        end
        @(negedge CLK);
        check("wrap_rd_ptr", 32'(rd_ptr), 32'h02);
        tick();

        // Flush with 6 words pending, one buffered and one in flight
        dout_ready = 1'b0;
        push(8, 8'hC0);
        tick();
        tick();
        @(negedge CLK);
        check("fl_level", 32'(level),      32'd6);
        check("fl_valid", 32'(dout_valid), 32'h1);
        check("fl_dout",  32'(dout),       32'hC0);
        tick();
        flush = 1'b1;
        @(negedge CLK);
        check("fl_no_issue", 32'(mem_re), 32'h0);
        tick();
        flush = 1'b0;
        @(negedge CLK);
        check("fl_rd_ptr", 32'(rd_ptr),     32'h0A);
        check("fl_empty",  32'(empty),      32'h1);
        check("fl_level0", 32'(level),      32'h0);
        check("fl_valid0", 32'(dout_valid), 32'h0);
        tick();
        @(negedge CLK);
        check("fl_late_dropped", 32'(dout_valid), 32'h0);
        tick();

        // Reset asserted mid-transfer clears at once
        push(4, 8'hE0);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_rd_ptr", 32'(rd_ptr),     32'h0);
        check("mid_rst_valid",  32'(dout_valid), 32'h0);
        check("mid_rst_mem_re", 32'(mem_re),     32'h0);
        check("mid_rst_dout",   32'(dout),       32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
